bnn_seq_ctrl: RTL

Parametrised instruction sequencer for the BNN accelerator.
- Fetches 16-bit instructions from the instruction SRAM (1-cycle read latency).
- Executes scalar register/branch instructions and nested hardware loops locally.
- Issues BNN-core commands over a valid/ready handshake and stalls on core busy.
- Generalises the earlier controller: register count, PC width and loop depth are parametrised; it adds a separate compare flag, a loop stack, a fetch handshake and error reporting.

---
 rtl/bnn_seq_pkg.sv | 37 +++
 rtl/bnn_loop_stack.sv | 84 ++++++++
 rtl/bnn_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bnn_seq_pkg.sv
// Shared opcodes, FSM states, error codes and instruction field positions
// for the BNN instruction sequencer.
package bnn_seq_pkg;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_LDL   = 5'd1;
  localparam logic [4:0] OP_LDH   = 5'd2;
  localparam logic [4:0] OP_ADDI  = 5'd3;
  localparam logic [4:0] OP_CMPGT = 5'd4;
  localparam logic [4:0] OP_JMPB  = 5'd5;
  localparam logic [4:0] OP_LOOP  = 5'd6;
  localparam logic [4:0] OP_ENDL  = 5'd7;
  localparam logic [4:0] OP_CORE  = 5'd8;
  localparam logic [4:0] OP_WAIT  = 5'd9;
  localparam logic [4:0] OP_HALT  = 5'd10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_ISSUE,
    ST_WAIT,
    ST_HALT,
    ST_ERR
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd1;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
  localparam logic [1:0] ERR_UNDERFLOW = 2'd3;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 11;
  localparam int RD_HI  = 10;
  localparam int RD_LO  = 8;

endpackage

// File: rtl/bnn_loop_stack.sv
// Hardware loop stack: each entry holds the loop body start PC and the
// remaining iteration count; the top entry is read out combinationally.
module bnn_loop_stack
  import bnn_seq_pkg::*;
#(
  parameter int PC_W       = 10,
  parameter int LOOP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push,
  input  logic [PC_W-1:0] push_start,
  input  logic [7:0]      push_count,
  input  logic            pop,
  input  logic            dec,
  output logic            full,
  output logic            empty,
  output logic [PC_W-1:0] top_start,
  output logic [7:0]      top_count
);

  localparam int SP_W = $clog2(LOOP_DEPTH + 1);

  logic [SP_W-1:0] sp_q, sp_d, top_idx;
  logic [PC_W-1:0] start_q [LOOP_DEPTH];
  logic [PC_W-1:0] start_d [LOOP_DEPTH];
  logic [7:0]      count_q [LOOP_DEPTH];
  logic [7:0]      count_d [LOOP_DEPTH];

  assign full    = (sp_q == SP_W'(LOOP_DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q - SP_W'(1);

  // When empty, top_idx wraps past the last entry so no slot matches.
  always_comb begin
    top_start = '0;
    top_count = '0;
    for (int i = 0; i < LOOP_DEPTH; i++) begin
      if (top_idx == SP_W'(i)) begin
        top_start = start_q[i];
        top_count = count_q[i];
      end
    end
  end

  always_comb begin
    sp_d    = sp_q;
    start_d = start_q;
    count_d = count_q;
    if (clr) begin
      sp_d = '0;
    end else if (push && !full) begin
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        if (sp_q == SP_W'(i)) begin
          start_d[i] = push_start;
          count_d[i] = push_count;
        end
      end
      sp_d = sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_d = top_idx;
    end else if (dec && !empty) begin
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        if (top_idx == SP_W'(i)) count_d[i] = count_q[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp_q <= '0;
      for (int i = 0; i < LOOP_DEPTH; i++) begin
        start_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      sp_q    <= sp_d;
      start_q <= start_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bnn_seq_ctrl.sv
// BNN accelerator instruction sequencer: fetches 16-bit instructions, runs
// scalar/branch/loop instructions locally and hands CORE commands to the core.
module bnn_seq_ctrl
  import bnn_seq_pkg::*;
#(
  parameter int NREG       = 4,
  parameter int PC_W       = 10,
  parameter int LOOP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [PC_W-1:0] start_pc,
  output logic            inst_en,
  output logic [PC_W-1:0] inst_addr,
  input  logic [15:0]     inst_rdata,
  output logic            cmd_valid,
  output logic [10:0]     cmd_data,
  input  logic            cmd_ready,
  input  logic            core_busy,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [1:0]      err_code,
  input  logic [2:0]      dbg_sel,
  output logic [15:0]     dbg_data
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [15:0]     regs_q [NREG];
  logic [15:0]     regs_d [NREG];
  logic            flag_q, flag_d;
  logic [10:0]     cmd_data_q, cmd_data_d;
  logic            done_q, done_d, error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            busy_q, busy_d, inst_en_q, inst_en_d, cmd_valid_q, cmd_valid_d;

  logic [4:0]      opc;
  logic [2:0]      rd;
  logic [7:0]      imm;
  logic [15:0]     rd_val, reg_wdata;
  logic            rd_ok, rd_op, reg_we, fault;
  logic [1:0]      fault_code;

  logic            stk_clr, stk_push, stk_pop, stk_dec, stk_full, stk_empty;
  logic [PC_W-1:0] stk_top_start;
  logic [7:0]      stk_top_count, loop_count;

  assign opc        = inst_rdata[OPC_HI:OPC_LO];
  assign rd         = inst_rdata[RD_HI:RD_LO];
  assign imm        = inst_rdata[7:0];
  assign rd_ok      = (int'(rd) < NREG);
  assign rd_op      = opc inside {OP_LDL, OP_LDH, OP_ADDI, OP_CMPGT};
  assign pc_inc     = pc_q + PC_W'(1);
  assign loop_count = (imm == 8'd0) ? 8'd1 : imm;

  bnn_loop_stack #(
    .PC_W       (PC_W),
    .LOOP_DEPTH (LOOP_DEPTH)
  ) u_loop_stack (
    .clk        (clk),
    .rst        (rst),
    .clr        (stk_clr),
    .push       (stk_push),
    .push_start (pc_inc),
    .push_count (loop_count),
    .pop        (stk_pop),
    .dec        (stk_dec),
    .full       (stk_full),
    .empty      (stk_empty),
    .top_start  (stk_top_start),
    .top_count  (stk_top_count)
  );

  always_comb begin
    rd_val   = '0;
    dbg_data = '0;
    for (int i = 0; i < NREG; i++) begin
      if (rd == 3'(i))      rd_val   = regs_q[i];
      if (dbg_sel == 3'(i)) dbg_data = regs_q[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    regs_d     = regs_q;
    flag_d     = flag_q;
    cmd_data_d = cmd_data_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    stk_clr    = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_dec    = 1'b0;
    reg_we     = 1'b0;
    reg_wdata  = '0;
    fault      = 1'b0;
    fault_code = ERR_NONE;

    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        if (start) begin
          state_d    = ST_FETCH;
          pc_d       = start_pc;
          flag_d     = 1'b0;
          stk_clr    = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = ERR_NONE;
          for (int i = 0; i < NREG; i++) regs_d[i] = '0;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_inc;
        if (rd_op && !rd_ok) begin
          fault      = 1'b1;
          fault_code = ERR_ILLEGAL;
        end else begin
          case (opc)
            OP_NOP: ;
            OP_LDL: begin
              reg_we    = 1'b1;
              reg_wdata = {rd_val[15:8], imm};
            end
            OP_LDH: begin
              reg_we    = 1'b1;
              reg_wdata = {imm, rd_val[7:0]};
            end
            OP_ADDI: begin
              reg_we    = 1'b1;
              reg_wdata = rd_val + {8'd0, imm};
            end
            OP_CMPGT: flag_d = (rd_val > {8'd0, imm});
            OP_JMPB:  if (flag_q) pc_d = pc_q - PC_W'(inst_rdata[10:0]);
            OP_LOOP: begin
              if (stk_full) begin
                fault      = 1'b1;
                fault_code = ERR_OVERFLOW;
              end else begin
                stk_push = 1'b1;
              end
            end
            OP_ENDL: begin
              if (stk_empty) begin
                fault      = 1'b1;
                fault_code = ERR_UNDERFLOW;
              end else if (stk_top_count > 8'd1) begin
                stk_dec = 1'b1;
                pc_d    = stk_top_start;
              end else begin
                stk_pop = 1'b1;
              end
            end
            OP_CORE: begin
              cmd_data_d = inst_rdata[10:0];
              state_d    = ST_ISSUE;
              pc_d       = pc_q;
            end
            OP_WAIT: begin
              state_d = ST_WAIT;
              pc_d    = pc_q;
            end
            OP_HALT: begin
              state_d = ST_HALT;
              pc_d    = pc_q;
              done_d  = 1'b1;
            end
            default: begin
              fault      = 1'b1;
              fault_code = ERR_ILLEGAL;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (!core_busy) begin
          pc_d    = pc_inc;
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A fault leaves the PC on the offending instruction for inspection.
    if (fault) begin
      state_d    = ST_ERR;
      pc_d       = pc_q;
      error_d    = 1'b1;
      err_code_d = fault_code;
    end
    if (reg_we) begin
      for (int i = 0; i < NREG; i++) begin
        if (rd == 3'(i)) regs_d[i] = reg_wdata;
      end
    end

    busy_d      = state_d inside {ST_FETCH, ST_EXEC, ST_ISSUE, ST_WAIT};
    inst_en_d   = (state_d == ST_FETCH);
    cmd_valid_d = (state_d == ST_ISSUE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      flag_q      <= 1'b0;
      cmd_data_q  <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_code_q  <= ERR_NONE;
      busy_q      <= 1'b0;
      inst_en_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flag_q      <= flag_d;
      cmd_data_q  <= cmd_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
      busy_q      <= busy_d;
      inst_en_q   <= inst_en_d;
      cmd_valid_q <= cmd_valid_d;
      regs_q      <= regs_d;
    end
  end

  assign inst_en   = inst_en_q;
  assign inst_addr = pc_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule
